neuron_layer: RTL and testbench

Parametrised successor to the single-neuron datapath. It computes NUM_NEURONS fixed-point dot products, one per neuron, over a shared input vector of VEC_LEN elements, using one time-multiplexed signed MAC. Each neuron's result has optional ReLU and signed saturation applied, and results stream out indexed by neuron. Input and weight memories are written through a port, so no memory preload is needed.

---
 rtl/neuron_layer.sv | 172 +++++++++++++++++
 tb/tb_neuron_layer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer.sv
`default_nettype none
// ============================================================================
// Module   : neuron_layer
// Brief    : NUM_NEURONS fixed-point dot products over a shared input vector,
//            one time-multiplexed signed MAC, ReLU + saturation per neuron.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_layer #(
    parameter int DATA_WIDTH  = 16,
    parameter int VEC_LEN     = 8,
    parameter int NUM_NEURONS = 4,
    parameter int FRAC_BITS   = 8,
    localparam int ADDR_W     = $clog2(NUM_NEURONS * VEC_LEN),
    localparam int IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  relu_en_i,
    input  logic                  wr_en_i,
    input  logic                  wr_sel_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] out_o,
    output logic [IDX_W-1:0]      out_idx_o,
    output logic                  out_valid_o,
    output logic                  ready_o,
    output logic                  done_o
);

    localparam int K_W   = $clog2(VEC_LEN);
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(VEC_LEN);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_EMIT = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             n_q, n_d;
    logic [K_W-1:0]               k_q, k_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic                         relu_q, relu_d;
    logic [DATA_WIDTH-1:0]        out_q, out_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         valid_q, valid_d;
    logic                         done_q, done_d;

    logic signed [DATA_WIDTH-1:0] in_mem [VEC_LEN];
    logic signed [DATA_WIDTH-1:0] w_mem  [NUM_NEURONS*VEC_LEN];

    logic                         w_ready;
    logic [ADDR_W-1:0]            w_widx;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]      w_shift;
    logic [DATA_WIDTH-1:0]        w_sat;
    logic [DATA_WIDTH-1:0]        w_result;

    // The cycle carrying done still reads as busy, so ready rises one cycle
    // after the last result strobe.
    assign w_ready = (state_q == S_IDLE) && !done_q;

    always_ff @(posedge clk) begin
        if (!rst && wr_en_i && w_ready) begin
            if (wr_sel_i) begin
                if (int'(wr_addr_i) < NUM_NEURONS * VEC_LEN) begin
                    w_mem[wr_addr_i] <= wr_data_i;
                end
            end else if (int'(wr_addr_i) < VEC_LEN) begin
                in_mem[wr_addr_i[K_W-1:0]] <= wr_data_i;
            end
        end
    end

    assign w_widx  = ADDR_W'(int'(n_q) * VEC_LEN + int'(k_q));
    assign w_prod  = in_mem[k_q] * w_mem[w_widx];
    assign w_shift = acc_q >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shift[DATA_WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_shift < SAT_MIN) begin
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        w_result = (relu_q && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            relu_q  <= 1'b0;
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            relu_q  <= relu_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        acc_d   = acc_q;
        relu_d  = relu_q;
        out_d   = out_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && w_ready) begin
                    state_d = S_MAC;
                    n_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    relu_d  = relu_en_i;
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(w_prod);
                if (k_q == K_W'(VEC_LEN - 1)) begin
                    state_d = S_EMIT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_EMIT: begin
                out_d   = w_result;
                idx_d   = n_q;
                valid_d = 1'b1;
                if (n_q == IDX_W'(NUM_NEURONS - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    n_d     = n_q + 1'b1;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_o       = out_q;
    assign out_idx_o   = idx_q;
    assign out_valid_o = valid_q;
    assign done_o      = done_q;
    assign ready_o     = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_neuron_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_layer
// Brief    : Scoreboard bench for neuron_layer against a dot-product model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_layer;

    localparam int DW = 16;
    localparam int V  = 8;
    localparam int N  = 4;
    localparam int F  = 8;
    localparam int AW = $clog2(N * V);
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          relu_en;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] out_o;
    logic [IW-1:0] out_idx_o;
    logic          out_valid_o;
    logic          ready_o;
    logic          done_o;

    neuron_layer #(
        .DATA_WIDTH (DW),
        .VEC_LEN    (V),
        .NUM_NEURONS(N),
        .FRAC_BITS  (F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .relu_en_i  (relu_en),
        .wr_en_i    (wr_en),
        .wr_sel_i   (wr_sel),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .out_o      (out_o),
        .out_idx_o  (out_idx_o),
        .out_valid_o(out_valid_o),
        .ready_o    (ready_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint        cyc;
        int            idx;
        logic [DW-1:0] val;
        bit            last;
    } exp_t;

    exp_t                 q[$];
    logic signed [DW-1:0] m_in [V];
    logic signed [DW-1:0] m_w  [N*V];
    int                   cnt = 0;
    longint               cyc = 0;
    int                   epoch = 0;
    bit                   model_init = 1'b0;
    int                   n_checks = 0;
    int                   n_pass = 0;
    logic [DW-1:0]        res [N];

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: exact integer dot product, floor shift, clamp, ReLU.
    function automatic logic [DW-1:0] model_neuron(int n, bit relu);
        longint acc = 0;
        longint r;
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -(longint'(1) <<< (DW - 1));
        for (int k = 0; k < V; k++) acc += longint'(m_in[k]) * longint'(m_w[n*V+k]);
        r = acc >>> F;
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        if (relu && r < 0) r = 0;
        return r[DW-1:0];
    endfunction

    // Cycle-level model of acceptance: busy for N*(V+1)+1 cycles after start.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            cnt = 0;
            q.delete();
            epoch++;
            model_init = 1'b1;
        end else if (cnt > 0) begin
            cnt--;
        end else begin
            if (wr_en) begin
                if (wr_sel) begin
                    if (int'(wr_addr) < N * V) m_w[wr_addr] = wr_data;
                end else if (int'(wr_addr) < V) begin
                    m_in[wr_addr] = wr_data;
                end
            end
            if (start) begin
                for (int n = 0; n < N; n++) begin
                    exp_t e;
                    e.cyc  = cyc + longint'((n + 1) * (V + 1));
                    e.idx  = n;
                    e.val  = model_neuron(n, relu_en);
                    e.last = (n == N - 1);
                    q.push_back(e);
                end
                cnt = N * (V + 1) + 1;
            end
        end
    end

    int            mon_epoch = 0;
    logic [DW-1:0] last_out = '0;
    int            last_idx = 0;

    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        if (model_init) begin
            if (mon_epoch != epoch) begin
                mon_epoch = epoch;
                last_out  = '0;
                last_idx  = 0;
            end
            ev = (q.size() > 0) && (q[0].cyc == cyc);
            chk("out_valid", longint'(out_valid_o), longint'(ev));
            chk("ready", longint'(ready_o), longint'(cnt == 0));
            if (ev) begin
                e = q.pop_front();
                chk("out", longint'(out_o), longint'(e.val));
                chk("out_idx", longint'(out_idx_o), longint'(e.idx));
                chk("done", longint'(done_o), longint'(e.last));
                last_out = e.val;
                last_idx = e.idx;
            end else begin
                chk("done_idle", longint'(done_o), 0);
                chk("out_hold", longint'(out_o), longint'(last_out));
                chk("idx_hold", longint'(out_idx_o), longint'(last_idx));
            end
            if (out_valid_o) res[out_idx_o] = out_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && cnt != 0; i++) step();
        if (cnt != 0) begin
            n_checks++;
            $display("FAIL ready_timeout: model still busy, count %0d required 0", cnt);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && (q.size() != 0 || cnt != 0); i++) step();
        if (q.size() != 0 || cnt != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
        end
    endtask

    task automatic wr(bit sel, int addr, logic [DW-1:0] d);
        wait_ready();
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic run(bit relu);
        wait_ready();
        start   = 1'b1;
        relu_en = relu;
        step();
        start   = 1'b0;
        relu_en = ~relu;
    endtask

    task automatic clear_res();
        for (int n = 0; n < N; n++) res[n] = 'x;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; relu_en = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        for (int k = 0; k < V; k++) begin
            wr(1'b0, k, 16'h0100);
            wr(1'b1, 0*V + k, 16'h0100);
            wr(1'b1, 1*V + k, 16'hFF00);
            wr(1'b1, 2*V + k, DW'($urandom));
            wr(1'b1, 3*V + k, DW'($urandom));
        end

        clear_res();
        run(1'b0);
        drain();
        chk("basic_n0", longint'(res[0]), 'h0800);
        chk("neg_n1", longint'(res[1]), 'hF800);

        clear_res();
        run(1'b1);
        drain();
        chk("relu_n1", longint'(res[1]), 'h0000);
        chk("relu_n0", longint'(res[0]), 'h0800);

        // start and write while busy must both be dropped
        run(1'b0);
        repeat (5) step();
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 16'h1234;
        step();
        start = 1'b0; wr_en = 1'b0;
        drain();
        clear_res();
        run(1'b0);
        drain();
        chk("busy_wr_ignored", longint'(res[0]), 'h0800);

        wait_ready();
        start = 1'b1; relu_en = 1'b0;
        repeat (100) step();
        start = 1'b0;
        drain();

        // abort a run during neuron 1
        run(1'b0);
        repeat (12) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_res();
        run(1'b0);
        drain();
        chk("after_rst_n0", longint'(res[0]), 'h0800);
        chk("after_rst_n1", longint'(res[1]), 'hF800);

        for (int k = 0; k < V; k++) begin
            wr(1'b0, k, 16'h7FFF);
            wr(1'b1, 2*V + k, 16'h7FFF);
            wr(1'b1, 3*V + k, 16'h8000);
        end
        clear_res();
        run(1'b0);
        drain();
        chk("sat_pos", longint'(res[2]), 'h7FFF);
        chk("sat_neg", longint'(res[3]), 'h8000);

        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 10; w++) begin
                wr(1'($urandom), int'($urandom_range(N*V-1)), DW'($urandom));
            end
            if (it == 2) begin
                wait_ready();
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(3); wr_data = DW'($urandom);
                start = 1'b1; relu_en = 1'($urandom);
                step();
                wr_en = 1'b0; start = 1'b0; relu_en = ~relu_en;
            end else begin
                run(1'($urandom));
            end
            drain();
        end

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
